dmem_responder: RTL

Memory-side responder for the core's load/store port. It accepts one request at a time from the datapath's memory interface (address, write data, size, direction) and applies a configurable number of wait states. It performs RISC-V byte, half and word accesses against an internal word-organised array. It returns one response per request with sign- or zero-extended load data and an access-error flag.

---
 rtl/dmem_responder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Single-port data-memory responder: byte/half/word loads and stores with WAIT_CYCLES wait states.
// Optional access-error detection is compiled in with `define DMEM_ERR_EN.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  // With zero wait states the access happens on the acceptance edge itself,
  // so the decode looks at the live request while idle.
  logic        acc_we;
  logic [1:0]  acc_size;
  logic        acc_unsigned;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        acc_err;
  logic [AW-1:0] word_idx;
  logic [3:0]  byte_en;
  logic [31:0] wr_word;
  logic [31:0] rd_word;
  logic [31:0] load_val;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic        enter_resp;

  assign req_ready = reset && (state == S_IDLE);

  always_comb begin
    if (state == S_IDLE) begin
      acc_we       = req_we;
      acc_size     = req_size;
      acc_unsigned = req_unsigned;
      acc_addr     = req_addr;
      acc_wdata    = req_wdata;
    end else begin
      acc_we       = lat_we;
      acc_size     = lat_size;
      acc_unsigned = lat_unsigned;
      acc_addr     = lat_addr;
      acc_wdata    = lat_wdata;
    end
  end

`ifdef DMEM_ERR_EN
  assign acc_err = ((acc_size == 2'b01) && acc_addr[0])
                || ((acc_size == 2'b10) && (acc_addr[1:0] != 2'b00))
                || (acc_size == 2'b11)
                || ({2'b00, acc_addr[31:2]} >= 32'(DEPTH_WORDS));
`else
  // Upper address bits are dropped: the index wraps modulo the array depth.
  logic unused_addr_bits;
  assign unused_addr_bits = ^acc_addr[31:AW+2];
  assign acc_err = 1'b0;
`endif

  assign word_idx = acc_addr[AW+1:2];
  assign rd_word  = mem[word_idx];

  // Size 11 falls through to word handling; it is only reachable when errors are disabled.
  always_comb begin
    rd_byte = rd_word[8*acc_addr[1:0] +: 8];
    rd_half = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (acc_size)
      2'b00: begin
        byte_en  = 4'b0001 << acc_addr[1:0];
        wr_word  = {4{acc_wdata[7:0]}};
        load_val = acc_unsigned ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      end
      2'b01: begin
        byte_en  = acc_addr[1] ? 4'b1100 : 4'b0011;
        wr_word  = {2{acc_wdata[15:0]}};
        load_val = acc_unsigned ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
      end
      default: begin
        byte_en  = 4'b1111;
        wr_word  = acc_wdata;
        load_val = rd_word;
      end
    endcase
  end

  assign enter_resp = reset &&
                      (((state == S_IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                       ((state == S_WAIT) && (cnt == 4'd1)));

  // Array has no reset; writes are gated by reset through enter_resp.
  always_ff @(posedge clk) begin
    if (enter_resp && acc_we && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      cnt          <= 4'd0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 32'd0;
      rsp_err      <= 1'b0;
      lat_we       <= 1'b0;
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
      lat_addr     <= 32'd0;
      lat_wdata    <= 32'd0;
    end else begin
      rsp_valid <= enter_resp;
      if (enter_resp) begin
        rsp_rdata <= (acc_we || acc_err) ? 32'd0 : load_val;
        rsp_err   <= acc_err;
      end
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_we       <= req_we;
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            lat_addr     <= req_addr;
            lat_wdata    <= req_wdata;
            cnt          <= 4'(WAIT_CYCLES);
            state        <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_RESP;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
